// File: rtl/axistream_pack.sv
// axistream_pack
//   Width-up packer: gathers NUM_PACK consecutive DATA_WIDTH-bit AXI-Stream
//   words into one DATA_WIDTH*NUM_PACK-bit word. One word is assembled in an
//   accumulator while the previous packed word sits in the output register.
//   This lets a full-rate source keep streaming while the sink drains.
//
//   Optional feature macro: AXISTREAM_PACK_FLUSH_EN
//     defined   : src_tlast on any beat closes the group early; unfilled slots
//                 read 0 and dest_tcnt reports the filled count.
//     undefined : groups are always NUM_PACK words; dest_tcnt == NUM_PACK.
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   src_tvalid/src_tready/src_tdata/src_tlast      narrow input stream
//   dest_tvalid/dest_tready/dest_tdata/dest_tlast  packed output stream
//   dest_tcnt                           valid narrow words in dest_tdata

module axistream_pack #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PACK   = 4,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              src_tvalid,
   output logic                              src_tready,
   input  logic [DATA_WIDTH-1:0]             src_tdata,
   input  logic                              src_tlast,
   output logic                              dest_tvalid,
   input  logic                              dest_tready,
   output logic [DATA_WIDTH*NUM_PACK-1:0]    dest_tdata,
   output logic                              dest_tlast,
   output logic [$clog2(NUM_PACK+1)-1:0]     dest_tcnt
);

   localparam int OUT_W  = DATA_WIDTH * NUM_PACK;
   localparam int CNT_W  = $clog2(NUM_PACK);
   localparam int TCNT_W = $clog2(NUM_PACK + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] slot;
   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] acc_next;
   logic             out_free;
   logic             beat_last;
   logic             src_hs;
   logic             dest_hs;
   logic             group_done;
   logic [TCNT_W-1:0] tcnt_next;

   assign out_free = !dest_tvalid || dest_tready;

`ifdef AXISTREAM_PACK_FLUSH_EN
   assign beat_last = (cnt == CNT_W'(NUM_PACK - 1)) || src_tlast;
   assign tcnt_next = TCNT_W'(cnt) + TCNT_W'(1);
`else
   assign beat_last = (cnt == CNT_W'(NUM_PACK - 1));
   assign tcnt_next = TCNT_W'(NUM_PACK);
`endif

   // Only a group-completing beat needs room in the output register; other
   // beats land in the accumulator regardless of the sink.
   assign src_tready = rst_n && (out_free || !beat_last);
   assign src_hs     = src_tvalid && src_tready;
   assign dest_hs    = dest_tvalid && dest_tready;
   assign group_done = src_hs && beat_last;

   always_comb begin
      slot     = BIG_ENDIAN ? (CNT_W'(NUM_PACK - 1) - cnt) : cnt;
      acc_next = acc;
      acc_next[int'(slot)*DATA_WIDTH +: DATA_WIDTH] = src_tdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         acc         <= '0;
         dest_tvalid <= 1'b0;
         dest_tdata  <= '0;
         dest_tlast  <= 1'b0;
         dest_tcnt   <= '0;
      end else begin
         if (group_done) begin
            // Output register is free here (guaranteed by src_tready), so a
            // same-cycle dest handshake simply reloads with no bubble.
            dest_tdata  <= acc_next;
            dest_tlast  <= src_tlast;
            dest_tcnt   <= tcnt_next;
            dest_tvalid <= 1'b1;
            acc         <= '0;
            cnt         <= '0;
         end else begin
            if (src_hs) begin
               acc <= acc_next;
               cnt <= cnt + CNT_W'(1);
            end
            if (dest_hs) begin
               dest_tvalid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_axistream_pack.sv
module tb_axistream_pack;

   typedef struct packed {
      logic [31:0] data;
      logic        last;
      logic [2:0]  cnt;
   } exp_t;

`ifdef AXISTREAM_PACK_FLUSH_EN
   localparam bit FLUSH = 1'b1;
`else
   localparam bit FLUSH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        src_tvalid;
   logic [7:0]  src_tdata;
   logic        src_tlast;
   logic        dest_tready;

   logic        src_tready,  be_src_tready;
   logic        dest_tvalid, be_dest_tvalid;
   logic [31:0] dest_tdata,  be_dest_tdata;
   logic        dest_tlast,  be_dest_tlast;
   logic [2:0]  dest_tcnt,   be_dest_tcnt;

   int checks   = 0;
   int failures = 0;

   exp_t q_le[$];
   exp_t q_be[$];
   int          m_n;
   logic [31:0] m_le, m_be;

   always #5 clk = ~clk;

   axistream_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .src_tvalid(src_tvalid), .src_tready(src_tready),
      .src_tdata(src_tdata), .src_tlast(src_tlast),
      .dest_tvalid(dest_tvalid), .dest_tready(dest_tready),
      .dest_tdata(dest_tdata), .dest_tlast(dest_tlast), .dest_tcnt(dest_tcnt)
   );

   axistream_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .BIG_ENDIAN(1'b1)) u_dut_be (
      .clk(clk), .rst_n(rst_n),
      .src_tvalid(src_tvalid), .src_tready(be_src_tready),
      .src_tdata(src_tdata), .src_tlast(src_tlast),
      .dest_tvalid(be_dest_tvalid), .dest_tready(dest_tready),
      .dest_tdata(be_dest_tdata), .dest_tlast(be_dest_tlast), .dest_tcnt(be_dest_tcnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_n  = 0;
      m_le = '0;
      m_be = '0;
   endtask

   task automatic model_push(input logic [7:0] d, input logic l);
      m_le = m_le | (32'(d) << (8 * m_n));
      m_be = m_be | (32'(d) << (8 * (3 - m_n)));
      m_n++;
      if (m_n == 4 || (FLUSH && l)) begin
         q_le.push_back('{data: m_le, last: l, cnt: 3'(m_n)});
         q_be.push_back('{data: m_be, last: l, cnt: 3'(m_n)});
         model_reset();
      end
   endtask

   // Drive one source word, wait (bounded) for acceptance; returns stall cycles.
   task automatic send(input logic [7:0] d, input logic l, output int waits);
      bit done;
      src_tvalid = 1'b1;
      src_tdata  = d;
      src_tlast  = l;
      waits      = 0;
      done       = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (src_tready) done = 1'b1;
         else begin
            waits++;
            if (waits > 50) begin
               checks++;
               failures++;
               $error("FAIL send_timeout got=stalled exp=accepted data=0x%0h", d);
               done = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      src_tvalid = 1'b0;
      if (waits <= 50) model_push(d, l);
   endtask

   // Scoreboard: compare each dest handshake against the queued expectation.
   always @(negedge clk) begin
      if (rst_n && dest_tvalid && dest_tready) begin
         if (q_le.size() == 0) chk("le_unexpected_word", dest_tdata, 32'hxxxx_xxxx);
         else begin
            exp_t e;
            e = q_le.pop_front();
            chk("le_data", dest_tdata, e.data);
            chk("le_last", 32'(dest_tlast), 32'(e.last));
            chk("le_tcnt", 32'(dest_tcnt), 32'(e.cnt));
         end
      end
      if (rst_n && be_dest_tvalid && dest_tready) begin
         if (q_be.size() == 0) chk("be_unexpected_word", be_dest_tdata, 32'hxxxx_xxxx);
         else begin
            exp_t e;
            e = q_be.pop_front();
            chk("be_data", be_dest_tdata, e.data);
            chk("be_last", 32'(be_dest_tlast), 32'(e.last));
            chk("be_tcnt", 32'(be_dest_tcnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      int w;
      logic [7:0] hold_word;
      model_reset();
      rst_n       = 1'b0;
      src_tvalid  = 1'b0;
      src_tdata   = '0;
      src_tlast   = 1'b0;
      dest_tready = 1'b0;
      #12;
      chk("rst_src_tready", 32'(src_tready), 0);
      chk("rst_dest_tvalid", 32'(dest_tvalid), 0);
      chk("rst_dest_tdata", dest_tdata, 0);
      chk("rst_dest_tlast", 32'(dest_tlast), 0);
      chk("rst_dest_tcnt", 32'(dest_tcnt), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full-rate packing, sink always ready: no stalls expected.
      dest_tready = 1'b1;
      send(8'h11, 1'b0, w); chk("rate_w0", 32'(w), 0);
      send(8'h22, 1'b0, w); chk("rate_w1", 32'(w), 0);
      send(8'h33, 1'b0, w); chk("rate_w2", 32'(w), 0);
      send(8'h44, 1'b1, w); chk("rate_w3", 32'(w), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("single_cycle_valid", 32'(dest_tvalid), 0);

`ifdef AXISTREAM_PACK_FLUSH_EN
      send(8'hAA, 1'b0, w);
      send(8'hBB, 1'b1, w);
      send(8'h01, 1'b0, w);
      send(8'h02, 1'b0, w);
      send(8'h03, 1'b0, w);
      send(8'h04, 1'b1, w);
`else
      // Mid-group tlast is ignored; only the 4th beat's tlast is forwarded.
      send(8'h5A, 1'b0, w);
      send(8'h5B, 1'b1, w);
      send(8'h5C, 1'b0, w);
      send(8'h5D, 1'b0, w);
`endif
      repeat (3) @(posedge clk);
      #1;

      // Back-pressure: output held, source stalls only on the completing beat.
      dest_tready = 1'b0;
      for (int i = 1; i <= 7; i++) send(8'(8'h11 * i), 1'b0, w);
      hold_word  = 8'h88;
      src_tvalid = 1'b1;
      src_tdata  = hold_word;
      src_tlast  = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("hold_src_tready", 32'(src_tready), 0);
         chk("hold_dest_tvalid", 32'(dest_tvalid), 1);
         chk("hold_le_data", dest_tdata, 32'h44332211);
         chk("hold_be_data", be_dest_tdata, 32'h11223344);
      end
      @(posedge clk); #1;
      dest_tready = 1'b1;
      @(negedge clk);
      chk("release_src_tready", 32'(src_tready), 1);
      @(posedge clk); #1;
      src_tvalid = 1'b0;
      model_push(hold_word, 1'b0);
      @(negedge clk);
      chk("no_bubble_valid", 32'(dest_tvalid), 1);
      repeat (3) @(posedge clk);
      #1;

      // Async reset with a pending output word and a partial group.
      dest_tready = 1'b0;
      send(8'h01, 1'b0, w);
      send(8'h02, 1'b0, w);
      send(8'h03, 1'b0, w);
      send(8'h04, 1'b0, w);
      send(8'hA1, 1'b0, w);
      send(8'hA2, 1'b0, w);
      chk("pre_rst_valid", 32'(dest_tvalid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(dest_tvalid), 0);
      chk("async_rst_data", dest_tdata, 0);
      chk("async_rst_be_data", be_dest_tdata, 0);
      chk("async_rst_src_tready", 32'(src_tready), 0);
      q_le.delete();
      q_be.delete();
      model_reset();
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dest_tready = 1'b1;
      send(8'h01, 1'b0, w);
      send(8'h02, 1'b0, w);
      send(8'h03, 1'b0, w);
      send(8'h04, 1'b1, w);
      chk("post_rst_le_data", dest_tdata, 32'h04030201);
      chk("post_rst_be_data", be_dest_tdata, 32'h01020304);

      for (int i = 0; i < 20 && (q_le.size() != 0 || q_be.size() != 0); i++) @(posedge clk);
      #1;
      chk("le_queue_drained", 32'(q_le.size()), 0);
      chk("be_queue_drained", 32'(q_be.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
